// File: rtl/if_pipe_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, boot hold, stall and redirect handling.
// Optional macro IF_PERF_CNT_EN adds saturating fetch/stall/flush performance counters.
module if_pipe_stage #(
  parameter int         BOOT_CYCLES = 2,
  parameter logic [9:0] RESET_PC    = 10'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Data_Hazard,
  input  logic        branch_taken,
  input  logic [9:0]  branch_address,
  input  logic        jump,
  input  logic [9:0]  jump_address,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [9:0]  pc,
  output logic        IF_Flush,
  output logic [9:0]  if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t     state;
  logic [3:0] boot_cnt;
  logic [9:0] pc_plus4;
  logic [9:0] jump_target;
  logic [9:0] branch_target;
  logic       run_go;

  assign imem_addr     = pc;
  assign pc_plus4      = pc + 10'd4;
  assign jump_target   = jump_address & 10'h3FC;
  assign branch_target = branch_address & 10'h3FC;
  assign run_go        = (state == RUN) && Data_Hazard;
  assign IF_Flush      = (jump | branch_taken) & run_go;

  // Jump outranks branch; a stalled cycle drops the redirect since decode re-presents it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= BOOT;
      boot_cnt       <= '0;
      pc             <= RESET_PC;
      if_id_instr    <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          boot_cnt <= boot_cnt + 4'd1;
          if (boot_cnt == BOOT_LAST) state <= RUN;
        end
        RUN: begin
          if (Data_Hazard) begin
            if (jump || branch_taken) begin
              pc             <= jump ? jump_target : branch_target;
              if_id_instr    <= '0;
              if_id_pc_plus4 <= '0;
              if_id_valid    <= 1'b0;
            end else begin
              pc             <= pc_plus4;
              if_id_instr    <= imem_rdata;
              if_id_pc_plus4 <= pc_plus4;
              if_id_valid    <= 1'b1;
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_evt;
  logic stall_evt;

  assign fetch_evt = run_go && !jump && !branch_taken;
  assign stall_evt = (state == RUN) && !Data_Hazard;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (fetch_evt && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_evt && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (IF_Flush  && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_pipe_stage.sv
// Self-checking bench for if_pipe_stage: a behavioural model pushes expected IF/ID state
// into a scoreboard queue each cycle, and each scenario task pops and compares after the edge.
module tb_if_pipe_stage;

  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Data_Hazard = 1'b1;
  logic        branch_taken = 1'b0;
  logic [9:0]  branch_address = '0;
  logic        jump = 1'b0;
  logic [9:0]  jump_address = '0;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [9:0]  pc;
  logic        IF_Flush;
  logic [9:0]  if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  if_pipe_stage #(.BOOT_CYCLES(BC), .RESET_PC(10'd0)) dut (
    .clk(clk), .reset(reset), .Data_Hazard(Data_Hazard),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .jump(jump), .jump_address(jump_address),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc), .IF_Flush(IF_Flush),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: the word at byte address k holds k + 100.
  assign imem_rdata = 32'(imem_addr) + 32'd100;

  typedef struct packed {
    logic [9:0]  pc;
    logic [31:0] instr;
    logic [9:0]  pc4;
    logic        valid;
    logic        flush;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;
  logic obs_flush;

  logic [9:0]  m_pc;
  logic [31:0] m_instr;
  logic [9:0]  m_pc4;
  logic        m_valid;
  logic        m_run;
  int          m_cnt;

  task automatic model_reset();
    m_pc = 10'd0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_run = 1'b0; m_cnt = 0;
  endtask

  // Drives one cycle of inputs, samples IF_Flush before the edge and pushes the model's prediction.
  task automatic drive_cycle(input logic dh, input logic j, input logic b,
                             input logic [9:0] ja, input logic [9:0] ba);
    exp_t x;
    Data_Hazard = dh; jump = j; branch_taken = b; jump_address = ja; branch_address = ba;
    #1;
    obs_flush = IF_Flush;
    x.flush = m_run && dh && (j || b);
    if (!m_run) begin
      if (m_cnt == BC - 1) m_run = 1'b1;
      m_cnt++;
    end else if (dh) begin
      if (j || b) begin
        m_pc = j ? {ja[9:2], 2'b00} : {ba[9:2], 2'b00};
        m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
      end else begin
        m_instr = 32'(m_pc) + 32'd100;
        m_pc4 = m_pc + 10'd4;
        m_pc = m_pc4;
        m_valid = 1'b1;
      end
    end
    x.pc = m_pc; x.instr = m_instr; x.pc4 = m_pc4; x.valid = m_valid;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Data_Hazard = 1'b1; jump = 1'b1; branch_taken = 1'b1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, IF_Flush} !== {10'd0, 32'd0, 10'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got pc=%0d instr=%0d pc4=%0d v=%0b flush=%0b, want all 0",
               pc, if_id_instr, if_id_pc_plus4, if_id_valid, IF_Flush);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < BC + 1; i++) begin
      if (i < BC) drive_cycle(1'b1, 1'b1, 1'b1, 10'h40, 10'h80);
      else        drive_cycle(1'b1, 1'b0, 1'b0, 10'h0, 10'h0);
      e = sb.pop_front();
      n_checks++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, obs_flush} !== e) begin
        n_fail++;
        $display("[TB] FAIL boot_%0d: got pc=%0d instr=%0d pc4=%0d v=%0b flush=%0b, want pc=%0d instr=%0d pc4=%0d v=%0b flush=%0b",
                 i, pc, if_id_instr, if_id_pc_plus4, if_id_valid, obs_flush, e.pc, e.instr, e.pc4, e.valid, e.flush);
      end
    end
    n_checks++;
    if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid} !== {10'd4, 32'd100, 10'd4, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL first_fetch: got pc=%0d instr=%0d pc4=%0d v=%0b, want 4 100 4 1",
               pc, if_id_instr, if_id_pc_plus4, if_id_valid);
    end
  endtask

  task automatic test_wrap();
    int steps = 0;
    do begin
      drive_cycle(1'b1, 1'b0, 1'b0, 10'h0, 10'h0);
      e = sb.pop_front();
      steps++;
      n_checks++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, obs_flush} !== e) begin
        n_fail++;
        $display("[TB] FAIL wrap_seq: got pc=%0d instr=%0d pc4=%0d v=%0b, want pc=%0d instr=%0d pc4=%0d v=%0b",
                 pc, if_id_instr, if_id_pc_plus4, if_id_valid, e.pc, e.instr, e.pc4, e.valid);
      end
    end while (e.pc != 10'd0 && steps < 300);
    n_checks++;
    if ({pc, if_id_pc_plus4, if_id_instr} !== {10'd0, 10'd0, 32'd1120}) begin
      n_fail++;
      $display("[TB] FAIL wrap_point: got pc=%0d pc4=%0d instr=%0d, want 0 0 1120 (steps %0d)",
               pc, if_id_pc_plus4, if_id_instr, steps);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 20 && m_pc != 10'd16; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 10'h0, 10'h0);
      void'(sb.pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive_cycle(1'b0, i == 1, i == 2, 10'h50, 10'h60);
      else       drive_cycle(1'b1, 1'b0, 1'b0, 10'h0, 10'h0);
      e = sb.pop_front();
      n_checks++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, obs_flush} !== e) begin
        n_fail++;
        $display("[TB] FAIL stall_%0d: got pc=%0d instr=%0d pc4=%0d v=%0b flush=%0b, want pc=%0d instr=%0d pc4=%0d v=%0b flush=%0b",
                 i, pc, if_id_instr, if_id_pc_plus4, if_id_valid, obs_flush, e.pc, e.instr, e.pc4, e.valid, e.flush);
      end
    end
    n_checks++;
    if (pc !== 10'd20) begin
      n_fail++;
      $display("[TB] FAIL stall_release_pc: got %0d, want 20", pc);
    end
  endtask

  task automatic test_jump();
    for (int i = 0; i < 20 && m_pc != 10'd40; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 10'h0, 10'h0);
      void'(sb.pop_front());
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive_cycle(1'b1, 1'b1, 1'b0, 10'h103, 10'h0);
      else        drive_cycle(1'b1, 1'b0, 1'b0, 10'h0, 10'h0);
      e = sb.pop_front();
      n_checks++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, obs_flush} !== e) begin
        n_fail++;
        $display("[TB] FAIL jump_%0d: got pc=%0h instr=%0d pc4=%0h v=%0b flush=%0b, want pc=%0h instr=%0d pc4=%0h v=%0b flush=%0b",
                 i, pc, if_id_instr, if_id_pc_plus4, if_id_valid, obs_flush, e.pc, e.instr, e.pc4, e.valid, e.flush);
      end
    end
    n_checks++;
    if ({if_id_instr, if_id_pc_plus4} !== {32'd356, 10'h104}) begin
      n_fail++;
      $display("[TB] FAIL jump_target_fetch: got instr=%0d pc4=%0h, want 356 104", if_id_instr, if_id_pc_plus4);
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive_cycle(1'b0, 1'b1, 1'b1, 10'd200, 10'd80);
        1: drive_cycle(1'b1, 1'b1, 1'b1, 10'd200, 10'd80);
        3: drive_cycle(1'b1, 1'b0, 1'b1, 10'd0, 10'h2A7);
        default: drive_cycle(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
      endcase
      e = sb.pop_front();
      n_checks++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, obs_flush} !== e) begin
        n_fail++;
        $display("[TB] FAIL priority_%0d: got pc=%0d instr=%0d pc4=%0d v=%0b flush=%0b, want pc=%0d instr=%0d pc4=%0d v=%0b flush=%0b",
                 i, pc, if_id_instr, if_id_pc_plus4, if_id_valid, obs_flush, e.pc, e.instr, e.pc4, e.valid, e.flush);
      end
      if (i == 1) begin
        n_checks++;
        if (pc !== 10'd200) begin
          n_fail++;
          $display("[TB] FAIL jump_over_branch: got pc=%0d, want 200", pc);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive_cycle(1'b0, 1'b0, 1'b0, 10'h0, 10'h0);
      else        drive_cycle(1'b1, 1'b0, 1'b0, 10'h0, 10'h0);
      void'(sb.pop_front());
      Data_Hazard = (k == 1); jump = 1'b1;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, IF_Flush} !== {10'd0, 32'd0, 10'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL async_reset_%0d: got pc=%0d instr=%0d pc4=%0d v=%0b flush=%0b, want all 0",
                 k, pc, if_id_instr, if_id_pc_plus4, if_id_valid, IF_Flush);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
    end
    for (int i = 0; i < BC + 2; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 10'h0, 10'h0);
      e = sb.pop_front();
      n_checks++;
      if ({pc, if_id_instr, if_id_pc_plus4, if_id_valid, obs_flush} !== e) begin
        n_fail++;
        $display("[TB] FAIL reboot_%0d: got pc=%0d instr=%0d pc4=%0d v=%0b, want pc=%0d instr=%0d pc4=%0d v=%0b",
                 i, pc, if_id_instr, if_id_pc_plus4, if_id_valid, e.pc, e.instr, e.pc4, e.valid);
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_wrap();
    test_stall();
    test_jump();
    test_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_pipe_stage.md
Name: if_pipe_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the decode stage and feeds it if_id_instr and if_id_pc_plus4.
- Owns the 10-bit PC and drives the instruction-memory address.
- Applies redirects (jump and taken branch) resolved in decode, and raises IF_Flush for them.
- Honours the load-use stall (Data_Hazard low = stall).
- Holds the pipe empty for a programmable number of boot cycles after reset.

Parameters:
BOOT_CYCLES, 2, cycles after reset release during which the PC and IF/ID are held (range 1..15)
RESET_PC, 10'd0, PC value loaded on reset (word aligned)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
Data_Hazard  in  1  1 = proceed, 0 = stall (hold PC and IF/ID)
branch_taken  in  1  decode resolved a taken branch this cycle
branch_address  in  10  branch target from decode
jump  in  1  decode holds a jump this cycle
jump_address  in  10  jump target from decode
imem_addr  out  10  byte address to instruction memory (combinational read)
imem_rdata  in  32  instruction word at imem_addr, same cycle
pc  out  10  current PC
IF_Flush  out  1  redirect accepted this cycle; decode squashes its controls
if_id_pc_plus4  out  10  registered PC+4 of the instruction in IF/ID
if_id_instr  out  32  registered instruction, 32'd0 = NOP
if_id_valid  out  1  IF/ID holds a real fetched instruction

Behaviour:
- Reset (async, any time, including mid-boot or mid-stall):
  - pc = RESET_PC; if_id_instr = 0; if_id_pc_plus4 = 0; if_id_valid = 0.
  - FSM in BOOT with boot counter = 0.
  - IF_Flush = 0 while in reset.
- imem_addr = pc. pc_plus4 = pc + 4, mod 1024; wraps 1020 -> 0.
- Targets: bits [1:0] of branch_address and jump_address are forced to 0 before loading into the PC.
- FSM state BOOT:
  - pc, IF/ID and if_id_valid held.
  - IF_Flush forced to 0; all inputs ignored.
  - Counter increments every cycle. When counter = BOOT_CYCLES-1, next state is RUN.
- FSM state RUN: remains there until reset. Per-cycle priority:
  1. Data_Hazard = 0: pc held, IF/ID held (including valid), IF_Flush = 0. Any redirect is ignored; decode re-presents it next cycle.
  2. jump = 1: pc <= jump_address; IF/ID <= NOP (instr 0, pc_plus4 0, valid 0); IF_Flush = 1.
  3. branch_taken = 1: same as jump, but pc <= branch_address. If jump and branch_taken are both high, jump wins.
  4. Otherwise: pc <= pc_plus4; if_id_instr <= imem_rdata; if_id_pc_plus4 <= pc_plus4; if_id_valid <= 1.
- IF_Flush is combinational: (jump | branch_taken) & Data_Hazard & (state == RUN).
- Redirect penalty: exactly one bubble per taken jump/branch. The target instruction appears in IF/ID two edges after the redirect cycle.
- Stall latency: zero. The PC does not advance on the edge that ends a cycle with Data_Hazard = 0.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds three outputs, perf_fetch_cnt, perf_stall_cnt and perf_flush_cnt, each 32 bits.
  - They count RUN cycles that load a valid instruction, stall cycles in RUN, and accepted redirects.
  - All reset to 0 asynchronously, saturate at 32'hFFFF_FFFF, and do not count during BOOT.
- Undefined: the outputs and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then release with BOOT_CYCLES = 2 and imem[k] = k + 100 -> pc holds 0 for 2 edges. Third edge: if_id_instr = 100, if_id_pc_plus4 = 4, valid = 1, pc = 4.
- Sequential run to the top of memory -> after pc = 1020 the next pc = 0 and if_id_pc_plus4 = 0 (wrap).
- Hold Data_Hazard = 0 for 3 cycles at pc = 16 -> pc, if_id_instr and if_id_pc_plus4 unchanged and IF_Flush = 0. pc = 20 one edge after release.
- jump = 1 with jump_address = 10'h103 at pc = 40 -> IF_Flush = 1 that cycle; next pc = 10'h100; IF/ID = NOP with valid 0; next edge loads imem[0x100].
- jump, branch_taken and Data_Hazard = 0 all asserted together -> no redirect and IF_Flush = 0. Deassert the stall with jump and branch_taken still high, jump_address = 200, branch_address = 80 -> pc <= 200.
- Assert reset mid-stall and mid-boot -> all outputs return to reset values immediately (asynchronously), and the BOOT count restarts.
